// File: rtl/adder_serial_ctrl.sv
// adder_serial_ctrl: WIDTH-bit add/subtract built from one 4-bit adder stepped
// over WIDTH/4 cycles, least-significant nibble first, with the ripple carry
// held in a register between steps. Also holds the shared adder_4bits datapath.

module adder_4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [4:0] sum;

   // Plain 4-bit ripple add with carry in/out
   always_comb begin
      sum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
      s   = sum[3:0];
      co  = sum[4];
   end

endmodule

module adder_serial_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] s_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic             co_q;
   logic             ovf_q;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_s;
   logic             nib_co;
   logic             last_d;
   logic             ovf_d;

   // Select the active nibble of each latched operand and splice its sum into the result
   always_comb begin
      nib_a    = opa_q[{idx_q, 2'b00} +: 4];
      nib_b    = opb_q[{idx_q, 2'b00} +: 4];
      result_d = result_q;
      result_d[{idx_q, 2'b00} +: 4] = nib_s;
      last_d   = (idx_q == IW'(N - 1));
      ovf_d    = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (nib_s[3] != opa_q[WIDTH-1]);
   end

   adder_4bits u_adder (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (nib_s),
      .co (nib_co)
   );

   // Sequencer: accept in IDLE, one nibble per RUN cycle, one-cycle DONE pulse.
   // The working result is separate from s so s only moves on the final nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         s_q      <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         co_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  opa_q    <= a;
                  opb_q    <= sub ? ~b : b;
                  carry_q  <= sub ? 1'b1 : ci;
                  idx_q    <= '0;
                  result_q <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               result_q <= result_d;
               carry_q  <= nib_co;
               if (last_d) begin
                  s_q     <= result_d;
                  co_q    <= nib_co;
                  ovf_q   <= ovf_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers
   always_comb begin
      busy = busy_q;
      done = done_q;
      s    = s_q;
      co   = co_q;
      ovf  = ovf_q;
   end

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Testbench for adder_serial_ctrl: behavioural reference model compared every
// cycle, directed cases with literal expectations, and a long random run with
// start held high.

module tb_adder_serial_ctrl;

   localparam int W = 16;
   localparam int N = W / 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sub;
   logic          ci;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  s;
   logic          co;
   logic          ovf;

   int n_cmp = 0;
   int n_bad = 0;

   adder_serial_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .co    (co),
      .ovf   (ovf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counts cycles since acceptance, result by plain arithmetic
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic         m_co   = 1'b0;
   logic         m_ovf  = 1'b0;
   logic [W-1:0] m_s    = '0;
   logic [W-1:0] m_a, m_b;
   logic         m_c;
   logic [W:0]   m_full;
   int           m_k = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_k = 0; m_busy = 1'b0; m_done = 1'b0;
         m_s = '0; m_co = 1'b0; m_ovf = 1'b0;
      end else if (m_k == 0) begin
         m_done = 1'b0;
         if (start) begin
            m_a = a;
            m_b = sub ? ~b : b;
            m_c = sub ? 1'b1 : ci;
            m_k = 1;
            m_busy = 1'b1;
         end
      end else begin
         m_k++;
         if (m_k == N + 1) begin
            m_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};
            m_s    = m_full[W-1:0];
            m_co   = m_full[W];
            m_ovf  = (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
            m_done = 1'b1;
         end else if (m_k == N + 2) begin
            m_k = 0; m_busy = 1'b0; m_done = 1'b0;
         end
      end
   end

   bit chk_en = 1'b0;
   bit spc_en = 1'b0;
   int cyc = 0;
   int ndone = 0;
   int last_done = -1;

   // Compare process: DUT against model on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         check("busy", busy, m_busy);
         check("done", done, m_done);
         if (!m_busy || m_done) begin
            check("s", s, m_s);
            check("co", co, m_co);
            check("ovf", ovf, m_ovf);
         end
         if (done === 1'b1) begin
            ndone++;
            if (spc_en) begin
               if (last_done >= 0) check("done_spacing", cyc - last_done, 6);
               last_done = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (done !== 1'b1 && n < 20);
      if (done !== 1'b1) check("done_timeout", done, 1);
   endtask

   task automatic do_op(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ici, input logic isub,
                        input logic [W-1:0] es, input logic eco, input logic eovf);
      int n;
      a = ia; b = ib; ci = ici; sub = isub; start = 1'b1;
      tick();
      start = 1'b0;
      check({nm, "_busy0"}, busy, 1);
      wait_done(n);
      check({nm, "_latency"}, n, N);
      check({nm, "_s"}, s, es);
      check({nm, "_co"}, co, eco);
      check({nm, "_ovf"}, ovf, eovf);
      tick();
      check({nm, "_idle"}, busy, 0);
   endtask

   initial begin
      int n;
      int d0;
      int target;
      int guard;
      rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_s", s, 0);
      rst = 1'b0;
      tick();

      do_op("add5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      do_op("carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op("ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op("sub",     16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op("addci",   16'h0F0F, 16'h00F0, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

      // start re-pulsed during RUN must be ignored
      a = 16'h1111; b = 16'h2222; ci = 1'b0; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
      d0 = ndone;
      tick();
      start = 1'b0;
      wait_done(n);
      check("ignore_s", s, 16'h3333);
      repeat (6) tick();
      check("ignore_one_done", ndone - d0, 1);

      // reset in the middle of RUN aborts the operation
      a = 16'h1234; b = 16'h0001; ci = 1'b0; sub = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_s", s, 0);
      check("abort_co", co, 0);
      check("abort_ovf", ovf, 0);
      d0 = ndone;
      repeat (8) tick();
      check("abort_no_done", ndone - d0, 0);
      do_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      // start held high with random operands
      spc_en = 1'b1;
      target = ndone + 1000;
      guard = 0;
      start = 1'b1;
      while (ndone < target && guard < 7000) begin
         a = W'($urandom);
         b = W'($urandom);
         ci = 1'($urandom);
         sub = 1'($urandom);
         tick();
         guard++;
      end
      if (ndone < target) check("rand_timeout", ndone, target);
      start = 1'b0;
      spc_en = 1'b0;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
